wave_meas_ctrl: RTL and testbench

Measurement sequencer for the audio wave-analysis path. It selects the left or right inverse-filtered channel and discards settling samples. It then arms on a falling zero crossing, measures the sample count spanning NUM_CYC full periods and the peak-to-peak amplitude, and returns a registered result with a done pulse. It sits between the inverse-filter outputs and the display/UART reporting logic and replaces free-running, unsequenced analysis with a start/done transaction.

---
 rtl/wave_meas_ctrl.sv | 172 +++++++++++++++++
 tb/tb_wave_meas_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_meas_ctrl.sv
// Measurement sequencer: selects a channel, settles, arms on a falling zero crossing,
// then measures period (sample count over NUM_CYC cycles) and peak-to-peak amplitude.
`timescale 1ns/1ps
module wave_meas_ctrl #(
    parameter int NUM_CYC = 2,
    parameter int SETTLE  = 4,
    parameter int TMO     = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               ch_sel,
    input  logic               smpl_vld,
    input  logic signed [15:0] lft_inverse,
    input  logic signed [15:0] rght_inverse,
    output logic               busy,
    output logic               done,
    output logic               tmo,
    output logic [15:0]        period,
    output logic [15:0]        amp
);

    localparam logic [3:0]  NUM_CYC_L = 4'(NUM_CYC);
    localparam logic [7:0]  SETTLE_L  = 8'(SETTLE);
    localparam logic [15:0] TMO_L     = 16'(TMO);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ARM, S_MEAS, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_ch;
    logic signed [15:0] r_prev;
    logic [7:0]         r_settle_cnt;
    logic [15:0]        r_tmo_cnt;
    logic [15:0]        r_samp_cnt;
    logic [3:0]         r_cyc_cnt;
    logic signed [15:0] r_max;
    logic signed [15:0] r_min;
    logic [15:0]        r_period;
    logic [15:0]        r_amp;
    logic               r_tmo;

    logic signed [15:0] w_s;
    logic               w_xing;
    logic [15:0]        w_tmo_inc;
    logic               w_tmo_hit;
    logic               w_settle_last;
    logic [3:0]         w_cyc_inc;
    logic               w_complete;
    logic [15:0]        w_cnt_inc;
    logic signed [15:0] w_max_n;
    logic signed [15:0] w_min_n;
    logic               w_accept;

    assign w_s           = r_ch ? rght_inverse : lft_inverse;
    assign w_xing        = smpl_vld && (r_prev > 16'sd0) && (w_s <= 16'sd0);
    assign w_tmo_inc     = r_tmo_cnt + 16'd1;
    assign w_tmo_hit     = smpl_vld && (w_tmo_inc == TMO_L);
    assign w_settle_last = smpl_vld && (r_settle_cnt == SETTLE_L - 8'd1);
    assign w_cyc_inc     = r_cyc_cnt + 4'd1;
    assign w_complete    = (r_state == S_MEAS) && w_xing && (w_cyc_inc == NUM_CYC_L);
    assign w_cnt_inc     = (r_samp_cnt == 16'hFFFF) ? 16'hFFFF : r_samp_cnt + 16'd1;
    assign w_max_n       = (w_s > r_max) ? w_s : r_max;
    assign w_min_n       = (w_s < r_min) ? w_s : r_min;
    assign w_accept      = start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = (SETTLE_L == 8'd0) ? S_ARM : S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort)              w_next = S_IDLE;
                else if (w_tmo_hit)     w_next = S_DONE;
                else if (w_settle_last) w_next = S_ARM;
            end
            S_ARM: begin
                busy = 1'b1;
                if (abort)          w_next = S_IDLE;
                else if (w_tmo_hit) w_next = S_DONE;
                else if (w_xing)    w_next = S_MEAS;
            end
            S_MEAS: begin
                busy = 1'b1;
                if (abort)                        w_next = S_IDLE;
                else if (w_complete || w_tmo_hit) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch         <= 1'b0;
            r_prev       <= '0;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_samp_cnt   <= '0;
            r_cyc_cnt    <= '0;
            r_max        <= '0;
            r_min        <= '0;
            r_period     <= '0;
            r_amp        <= '0;
            r_tmo        <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_ch         <= ch_sel;
                r_prev       <= '0;
                r_settle_cnt <= '0;
                r_tmo_cnt    <= '0;
                r_samp_cnt   <= '0;
                r_cyc_cnt    <= '0;
                r_max        <= 16'sh8000;
                r_min        <= 16'sh7FFF;
            end
        end else if (r_state != S_DONE && !abort && smpl_vld) begin
            r_prev    <= w_s;
            r_tmo_cnt <= w_tmo_inc;
            case (r_state)
                S_SETTLE: r_settle_cnt <= r_settle_cnt + 8'd1;
                S_ARM: begin
                    if (w_xing) begin
                        r_max      <= w_s;
                        r_min      <= w_s;
                        r_samp_cnt <= '0;
                        r_cyc_cnt  <= '0;
                    end
                end
                S_MEAS: begin
                    r_samp_cnt <= w_cnt_inc;
                    r_max      <= w_max_n;
                    r_min      <= w_min_n;
                    if (w_xing) r_cyc_cnt <= w_cyc_inc;
                end
                default: ;
            endcase
            // Completion beats timeout when both land on the same sample.
            // max >= min, so the 16-bit wrapped difference is the exact unsigned span.
            if (w_complete) begin
                r_period <= w_cnt_inc;
                r_amp    <= 16'(w_max_n - w_min_n);
                r_tmo    <= 1'b0;
            end else if (w_tmo_hit) begin
                r_period <= '0;
                r_amp    <= '0;
                r_tmo    <= 1'b1;
            end
        end
    end

    assign period = r_period;
    assign amp    = r_amp;
    assign tmo    = r_tmo;

endmodule

// File: tb/tb_wave_meas_ctrl.sv
// Self-checking bench for wave_meas_ctrl: table of waveforms plus abort/reset/start-spam sequences.
`timescale 1ns/1ps
module tb_wave_meas_ctrl;

    logic               clk = 1'b0;
    logic               rst_n, start, abort, ch_sel, smpl_vld;
    logic signed [15:0] lft, rght;
    logic               busy, done, tmo;
    logic [15:0]        period, amp;

    always #5 clk = ~clk;

    wave_meas_ctrl #(.NUM_CYC(2), .SETTLE(4), .TMO(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_sel(ch_sel),
        .smpl_vld(smpl_vld), .lft_inverse(lft), .rght_inverse(rght),
        .busy(busy), .done(done), .tmo(tmo), .period(period), .amp(amp)
    );

    typedef struct {
        logic ch;
        int   gap;
        int   pos;
        int   neg;
        int   half;
        int   exp_per;
        int   exp_amp;
        int   exp_tmo;
        int   exp_n;
    } vec_t;

    typedef struct {
        int per;
        int amp;
        int tmo;
    } res_t;

    vec_t vecs[7];
    res_t sb[$];
    res_t got_r;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_per = 0, last_amp = 0, last_tmo = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] wave(input vec_t v, input int n);
        return ((((n - 1) / v.half) % 2) == 0) ? 16'(v.pos) : 16'(v.neg);
    endfunction

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            chk("busy_low_at_done", int'(busy), 0);
            chk("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: got done with no outstanding request at %0t", $time);
            end else begin
                got_r = sb.pop_front();
                chk("period", int'(period), got_r.per);
                chk("amp", int'(amp), got_r.amp);
                chk("tmo", int'(tmo), got_r.tmo);
            end
        end
        prev_done = done;
    end

    // mode 0: full measurement; 1: abort after sample stop_at; 2: reset after sample stop_at
    task automatic run_meas(input vec_t v, input int mode, input int stop_at, input bit spam);
        int n;
        int i;
        bit got;
        bit vld_l;
        @(negedge clk);
        start    = 1'b1;
        ch_sel   = v.ch;
        abort    = 1'b0;
        smpl_vld = 1'b0;
        if (mode == 0) begin
            sb.push_back('{per: v.exp_per, amp: v.exp_amp, tmo: v.exp_tmo});
        end
        @(negedge clk);
        if (!spam) start = 1'b0;
        ch_sel = ~v.ch;
        chk("busy_after_start", int'(busy), 1);
        n = 0;
        i = 0;
        got = 1'b0;
        while (!got && i < 3000) begin
            vld_l = ((i % v.gap) == v.gap - 1);
            i++;
            smpl_vld = vld_l;
            if (vld_l) n++;
            if (v.ch) begin
                rght = wave(v, n);
                lft  = 16'sd3000;
            end else begin
                lft  = wave(v, n);
                rght = 16'sd3000;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                chk("done_after_valid", int'(vld_l), 1);
                chk("terminating_sample", n, v.exp_n);
            end else if (mode != 0 && vld_l && n == stop_at) begin
                smpl_vld = 1'b0;
                start    = 1'b0;
                if (mode == 1) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_period_held", int'(period), last_per);
                    chk("abort_amp_held", int'(amp), last_amp);
                    chk("abort_tmo_held", int'(tmo), last_tmo);
                end else begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_done", int'(done), 0);
                    chk("rst_period", int'(period), 0);
                    chk("rst_amp", int'(amp), 0);
                    chk("rst_tmo", int'(tmo), 0);
                    last_per = 0;
                    last_amp = 0;
                    last_tmo = 0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                repeat (4) @(negedge clk);
                chk("idle_after_stop", int'(busy), 0);
                return;
            end
        end
        smpl_vld = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL no_done: got no done within budget, expected done after sample %0d", v.exp_n);
        end
        if (mode == 0) begin
            last_per = v.exp_per;
            last_amp = v.exp_amp;
            last_tmo = v.exp_tmo;
        end
        if (spam) begin
            @(negedge clk);
            chk("start_in_done_ignored", int'(busy), 0);
            start = 1'b0;
        end
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ch_sel = 1'b0; smpl_vld = 1'b0;
        lft = '0; rght = '0;
        vecs[0] = '{1'b0, 1, 1000, -1000, 4, 16, 2000, 0, 21};
        vecs[1] = '{1'b1, 3, 1000, -1000, 4, 16, 2000, 0, 21};
        vecs[2] = '{1'b0, 1, 500, 500, 1000, 0, 0, 1, 64};
        vecs[3] = '{1'b1, 2, 700, -200, 3, 12, 900, 0, 22};
        vecs[4] = '{1'b0, 1, 300, -300, 40, 0, 0, 1, 64};
        vecs[5] = '{1'b0, 1, 32767, -32768, 2, 8, 65535, 0, 15};
        vecs[6] = '{1'b1, 1, 100, 0, 1, 4, 100, 0, 10};

        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_tmo", int'(tmo), 0);
        chk("reset_period", int'(period), 0);
        chk("reset_amp", int'(amp), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_meas(vecs[k], 0, 0, 1'b0);

        run_meas(vecs[0], 0, 0, 1'b0);
        run_meas(vecs[0], 1, 10, 1'b0);
        run_meas(vecs[0], 0, 0, 1'b0);

        run_meas(vecs[1], 0, 0, 1'b1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", int'(busy), 0);
        @(negedge clk);
        chk("start_abort_idle_hold", int'(busy), 0);

        run_meas(vecs[0], 2, 12, 1'b0);
        run_meas(vecs[0], 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
